// File: rtl/seg_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_mon_pkg
// Description : Shared definitions for the seven-segment frame monitor:
//               segment bit positions, hex glyph table, monitor states and
//               the glyph-to-hex decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_mon_pkg;

    // Bit positions on the {dp,g,f,e,d,c,b,a} segment bus
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Glyph for hex value i lives at index i (segments g..a, dp excluded)
    localparam logic [6:0] HEX_GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2
    } mon_state_t;

    // Returns {valid, digit}; unknown glyphs decode to {0, 0}
    function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
        logic [4:0] result;
        result = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (seg == HEX_GLYPHS[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_frame_monitor_filter.sv
`default_nettype none
// ============================================================================
// Module      : seg_stable_filter
// Description : Synchronises the segment bus and tracks how long the
//               synchronised value has been unchanged. 'stable' is high once
//               STABLE_CYCLES identical synchronised samples have been seen.
//               clear resets the tracker only; the synchroniser keeps running.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_stable_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] seg_in,
    output logic [7:0] candidate,
    output logic       stable
);

    localparam int                STAB_W   = $clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]                  candidate_q, candidate_d;
    logic [STAB_W-1:0]           stab_q, stab_d;
    logic [7:0]                  seg_s;

    assign seg_s = sync_q[SYNC_STAGES-1];

    // Next-state for the synchroniser shift chain and the stability tracker
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], seg_in};
        candidate_d = candidate_q;
        stab_d      = stab_q;
        if (clear) begin
            candidate_d = 8'd0;
            stab_d      = '0;
        end else if (seg_s != candidate_q) begin
            candidate_d = seg_s;
            stab_d      = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + STAB_W'(1);
        end
    end

    // Register the synchroniser and tracker state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            candidate_q <= 8'd0;
            stab_q      <= '0;
        end else begin
            sync_q      <= sync_d;
            candidate_q <= candidate_d;
            stab_q      <= stab_d;
        end
    end

    assign candidate = candidate_q;
    assign stable    = (stab_q == STAB_MAX);

endmodule
`default_nettype wire

// File: rtl/seg_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : seg_frame_monitor
// Description : Watches a seven-segment bus, commits each new stable pattern
//               as a frame, measures enabled clocks between frames, counts
//               frames and decodes the hex glyph shown.
//               Optional macro SEG_PERIOD_STATS_EN adds period_min/period_max.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_frame_monitor
    import seg_mon_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          seg_in,
    input  logic                enable,
    input  logic                clear,
    output logic                frame_valid,
    output logic [7:0]          frame_pattern,
    output logic [PERIOD_W-1:0] frame_period,
    output logic                period_overflow,
    output logic [15:0]         frame_count,
    output logic [3:0]          digit,
    output logic                digit_valid
`ifdef SEG_PERIOD_STATS_EN
    ,
    output logic [PERIOD_W-1:0] period_min,
    output logic [PERIOD_W-1:0] period_max
`endif
);

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    logic [7:0]          candidate;
    logic                stable;
    logic                commit;
    logic [4:0]          hex;
    logic [PERIOD_W-1:0] period_next;

    mon_state_t          state_q, state_d;
    logic                frame_valid_q, frame_valid_d;
    logic [7:0]          pattern_q, pattern_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         frames_q, frames_d;
    logic [3:0]          digit_q, digit_d;
    logic                digit_valid_q, digit_valid_d;
`ifdef SEG_PERIOD_STATS_EN
    logic [PERIOD_W-1:0] pmin_q, pmin_d;
    logic [PERIOD_W-1:0] pmax_q, pmax_d;
`endif

    seg_stable_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .seg_in    (seg_in),
        .candidate (candidate),
        .stable    (stable)
    );

    // A stable pattern commits if it differs from the shown one, or always for the first frame
    assign commit = enable && stable &&
                    ((candidate != pattern_q) || (state_q == S_FIRST));
    assign hex         = seg_to_hex(candidate[SEG_G:SEG_A]);
    assign period_next = (count_q == PERIOD_MAX) ? PERIOD_MAX : count_q + PERIOD_W'(1);

    // Frame commit, period measurement and monitor state transitions
    always_comb begin
        state_d       = state_q;
        frame_valid_d = 1'b0;
        pattern_d     = pattern_q;
        period_d      = period_q;
        count_d       = count_q;
        ovf_d         = ovf_q;
        frames_d      = frames_q;
        digit_d       = digit_q;
        digit_valid_d = digit_valid_q;
`ifdef SEG_PERIOD_STATS_EN
        pmin_d        = pmin_q;
        pmax_d        = pmax_q;
`endif
        if (clear) begin
            state_d       = S_FIRST;
            pattern_d     = 8'd0;
            period_d      = '0;
            count_d       = '0;
            ovf_d         = 1'b0;
            frames_d      = 16'd0;
            digit_d       = 4'd0;
            digit_valid_d = 1'b0;
`ifdef SEG_PERIOD_STATS_EN
            pmin_d        = '1;
            pmax_d        = '0;
`endif
        end else if (enable) begin
            if (commit) begin
                frame_valid_d = 1'b1;
                pattern_d     = candidate;
                digit_valid_d = hex[4];
                digit_d       = hex[3:0];
                period_d      = (state_q == S_FIRST) ? '0 : period_next;
                count_d       = '0;
                ovf_d         = 1'b0;
                frames_d      = frames_q + 16'd1;
                state_d       = S_RUN;
`ifdef SEG_PERIOD_STATS_EN
                if (state_q != S_FIRST) begin
                    if (period_next < pmin_q) pmin_d = period_next;
                    if (period_next > pmax_q) pmax_d = period_next;
                end
`endif
            end else begin
                if (count_q == PERIOD_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + PERIOD_W'(1);
                end
                if (state_q == S_HOLD) begin
                    state_d = S_RUN;
                end
            end
        end else if (state_q == S_RUN) begin
            // Frozen while disabled; the filter keeps tracking the bus
            state_d = S_HOLD;
        end
    end

    // Register monitor state and all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FIRST;
            frame_valid_q <= 1'b0;
            pattern_q     <= 8'd0;
            period_q      <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            frames_q      <= 16'd0;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
`ifdef SEG_PERIOD_STATS_EN
            pmin_q        <= '1;
            pmax_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            frame_valid_q <= frame_valid_d;
            pattern_q     <= pattern_d;
            period_q      <= period_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            frames_q      <= frames_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
`ifdef SEG_PERIOD_STATS_EN
            pmin_q        <= pmin_d;
            pmax_q        <= pmax_d;
`endif
        end
    end

    assign frame_valid     = frame_valid_q;
    assign frame_pattern   = pattern_q;
    assign frame_period    = period_q;
    assign period_overflow = ovf_q;
    assign frame_count     = frames_q;
    assign digit           = digit_q;
    assign digit_valid     = digit_valid_q;
`ifdef SEG_PERIOD_STATS_EN
    assign period_min      = pmin_q;
    assign period_max      = pmax_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_frame_monitor
// Description : Scoreboard bench for seg_frame_monitor. Stimulus is a list of
//               (pattern, hold) segments; the reference model predicts which
//               segments become frames and when, and a monitor compares every
//               frame_valid pulse against the predicted frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_frame_monitor;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int PERIOD_W      = 10;
    localparam int LAT           = SYNC_STAGES + STABLE_CYCLES + 1;
    localparam int PMAX          = (1 << PERIOD_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          seg_in = 8'h00;
    logic                enable = 1'b1;
    logic                clear = 1'b0;
    logic                frame_valid;
    logic [7:0]          frame_pattern;
    logic [PERIOD_W-1:0] frame_period;
    logic                period_overflow;
    logic [15:0]         frame_count;
    logic [3:0]          digit;
    logic                digit_valid;
`ifdef SEG_PERIOD_STATS_EN
    logic [PERIOD_W-1:0] period_min;
    logic [PERIOD_W-1:0] period_max;
`endif

    seg_frame_monitor #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .PERIOD_W      (PERIOD_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .seg_in          (seg_in),
        .enable          (enable),
        .clear           (clear),
        .frame_valid     (frame_valid),
        .frame_pattern   (frame_pattern),
        .frame_period    (frame_period),
        .period_overflow (period_overflow),
        .frame_count     (frame_count),
        .digit           (digit),
        .digit_valid     (digit_valid)
`ifdef SEG_PERIOD_STATS_EN
        ,
        .period_min      (period_min),
        .period_max      (period_max)
`endif
    );

    always #5 clk = ~clk;

    // Hex glyphs as listed for the display (index = hex value)
    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [7:0] pat;
        int         cyc;
        int         cnt;
        bit         first;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc = 0;
    int   en_edges = 0;

    // Reference-model state (stimulus side)
    logic [7:0] m_last_pat = 8'h00;
    int         m_count = 0;
    bit         m_first = 1'b1;
    logic [7:0] last_applied = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (enable) en_edges <= en_edges + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] ref_hex(input logic [7:0] p);
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == p[6:0]) return {1'b1, 4'(i)};
        end
        return 5'd0;
    endfunction

    // A pattern that stays long enough and differs from the shown one becomes a frame
    task automatic push_frame(input logic [7:0] p, input int at_cyc);
        exp_t e;
        if (m_first || p != m_last_pat) begin
            m_count    = (m_count + 1) & 16'hFFFF;
            e.pat      = p;
            e.cyc      = at_cyc;
            e.cnt      = m_count;
            e.first    = m_first;
            q.push_back(e);
            m_last_pat = p;
            m_first    = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic [7:0] p, input int h);
        seg_in       = p;
        last_applied = p;
        if (h >= STABLE_CYCLES) push_frame(p, cyc + LAT);
        repeat (h) step();
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] p;
        if ($urandom_range(0, 1) == 1) p = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
        else p = 8'($urandom);
        return p;
    endfunction

    // Monitor: every frame_valid pulse must match the oldest predicted frame
    initial begin : monitor
        exp_t e;
        int   base = 0;
        int   diff;
        int   exp_period;
        logic [4:0] h;
        forever begin
            @(negedge clk);
            if (rst_n && frame_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame", {56'd0, frame_pattern}, 64'hFFFF);
                end else begin
                    e    = q.pop_front();
                    diff = en_edges - base;
                    base = en_edges;
                    exp_period = e.first ? 0 : ((diff > PMAX) ? PMAX : diff);
                    h = ref_hex(e.pat);
                    chk("frame_cycle", 64'(cyc), 64'(e.cyc));
                    chk("frame_pattern", 64'(frame_pattern), 64'(e.pat));
                    chk("digit_valid", 64'(digit_valid), 64'(h[4]));
                    chk("digit", 64'(digit), 64'(h[3:0]));
                    chk("frame_period", 64'(frame_period), 64'(exp_period));
                    chk("frame_count", 64'(frame_count), 64'(e.cnt));
                    chk("overflow_after_commit", 64'(period_overflow), 64'd0);
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] p;
        int         h;
        int         ke;

        // Reset state
        seg_in = 8'h3F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk("rst_frame_pattern", 64'(frame_pattern), 64'd0);
        chk("rst_frame_period", 64'(frame_period), 64'd0);
        chk("rst_overflow", 64'(period_overflow), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_digit", 64'({digit_valid, digit}), 64'd0);

        // First frame: 0x3F held from reset release
        step();
        rst_n = 1'b1;
        last_applied = 8'h3F;
        push_frame(8'h3F, cyc + LAT);
        repeat (30) step();

        // Alternating digits, 1000 clocks each
        seg(8'h06, 1000);
        seg(8'h5B, 1000);
        seg(8'h06, 1000);
        seg(8'h5B, 1000);

        // Short glitch inside a steady pattern
        seg(8'h3F, 20);
        seg(8'h7F, 2);
        seg(8'h3F, 20);
        chk("glitch_pattern_kept", 64'(frame_pattern), 64'h3F);

        // Non-glyph pattern
        seg(8'h49, 20);

        // Randomised segments including sub-threshold glitches
        for (int i = 0; i < 60; i++) begin
            do p = pick(); while (p == last_applied || p == 8'h66);
            h = $urandom_range(1, 10);
            seg(p, h);
        end

        // Period saturation
        seg(8'h66, 30);
        seg_in = 8'h6D;
        last_applied = 8'h6D;
        push_frame(8'h6D, cyc + LAT);
        repeat (1060) step();
        chk("overflow_before_commit", 64'(period_overflow), 64'd1);
        repeat (40) step();
        seg(8'h7D, 30);

        // Disabled window with a new pattern arriving while frozen
        enable = 1'b0;
        repeat (50) step();
        seg_in = 8'h77;
        last_applied = 8'h77;
        repeat (450) step();
        chk("hold_no_commit_count", 64'(frame_count), 64'(m_count));
        enable = 1'b1;
        push_frame(8'h77, cyc + 1);
        repeat (30) step();

        // clear on the same edge as a pending commit suppresses the frame
        enable = 1'b0;
        repeat (20) step();
        seg_in = 8'h79;
        last_applied = 8'h79;
        repeat (80) step();
        enable = 1'b1;
        clear  = 1'b1;
        step();
        clear  = 1'b0;
        ke = cyc;
        chk("clear_frame_valid", 64'(frame_valid), 64'd0);
        chk("clear_frame_count", 64'(frame_count), 64'd0);
        chk("clear_frame_pattern", 64'(frame_pattern), 64'd0);
        m_first    = 1'b1;
        m_count    = 0;
        m_last_pat = 8'h00;
        push_frame(8'h79, ke + STABLE_CYCLES + 1);
        repeat (40) step();

        chk("pending_frames_left", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
